// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response bus between the MEM stage and dm_responder
//
// Signals:
//    req_valid   MEM stage presents a request
//    mem_read    request is a load
//    mem_write   request is a store
//    addr        byte address (word index = addr[31:2])
//    write_data  store data
//    req_ready   responder can accept (IDLE only)
//    stall       pipeline hold request
//    resp_valid  one-cycle response pulse
//    read_data   load result, valid with resp_valid
//    addr_err    request was illegal, valid with resp_valid
// Modports: master = pipeline side, slave = responder side.

interface dm_responder_if;
   logic        req_valid;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        req_ready;
   logic        stall;
   logic        resp_valid;
   logic [31:0] read_data;
   logic        addr_err;

   modport master (
      output req_valid, mem_read, mem_write, addr, write_data,
      input  req_ready, stall, resp_valid, read_data, addr_err
   );

   modport slave (
      input  req_valid, mem_read, mem_write, addr, write_data,
      output req_ready, stall, resp_valid, read_data, addr_err
   );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - wait-state data memory serving MEM-stage loads/stores
//
// Parameters:
//    DEPTH    number of 32-bit words
//    LATENCY  wait cycles between accept and response (>= 1)
// Ports:
//    clk      rising-edge clock
//    rst_n    asynchronous active-low reset
//    bus      dm_responder_if.slave request/response bus

module dm_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   dm_responder_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic          lat_rd;
   logic          lat_wr;
   logic [31:0]   mem [DEPTH];

   logic          err;
   logic          access;
   logic [AW-1:0] idx;

   // Legality is judged on the latched request so input wiggles during
   // WAIT cannot change the outcome.
   assign err    = (lat_addr[1:0] != 2'b00)
                 | (lat_addr[31:2] >= 30'(DEPTH))
                 | (lat_rd == lat_wr);
   assign access = (state == WAIT) && (cnt == '0);
   assign idx    = lat_addr[AW+1:2];

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         lat_rd        <= 1'b0;
         lat_wr        <= 1'b0;
         bus.read_data <= '0;
         bus.addr_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.req_valid) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.write_data;
            lat_rd    <= bus.mem_read;
            lat_wr    <= bus.mem_write;
            cnt       <= CW'(LATENCY - 1);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            bus.addr_err  <= err;
            bus.read_data <= (!err && lat_rd) ? mem[idx] : '0;
         end
      end
   end

   // Array is deliberately unreset. A reset during WAIT forces state to
   // IDLE, so access is false on the next edge and the store is dropped.
   always_ff @(posedge clk) begin
      if (access && !err && lat_wr)
         mem[idx] <= lat_wdata;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nxt = WAIT;
         WAIT:    if (cnt == '0)     state_nxt = RESP;
         RESP:                       state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; stall is low in RESP so the pipeline
   // captures read_data on the RESP->IDLE edge.
   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.resp_valid = (state == RESP);
      bus.stall      = ((state == IDLE) && bus.req_valid) || (state == WAIT);
   end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder

module tb_dm_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dm_responder_if if0 ();
   dm_responder_if if1 ();

   dm_responder #(.DEPTH(64), .LATENCY(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   dm_responder #(.DEPTH(64), .LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        eerr;
   } vec_t;

   vec_t tab [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One request on the LATENCY=2 instance: checks accept cycle,
   // response latency, stall cycle count and response payload.
   task automatic run_req(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eerr);
      int  k;
      int  stalls;
      bit  seen;
      @(negedge clk);
      if0.req_valid  = 1'b1;
      if0.mem_read   = rd;
      if0.mem_write  = wr;
      if0.addr       = a;
      if0.write_data = wd;
      #1;
      chk({name, "_ready"}, 32'(if0.req_ready), 32'd1);
      stalls = if0.stall ? 1 : 0;
      @(posedge clk);
      #1;
      if0.req_valid  = 1'b0;
      if0.mem_read   = 1'b0;
      if0.mem_write  = 1'b0;
      if0.addr       = 32'hFFFF_FFFF;
      if0.write_data = 32'h0;
      k = 0;
      seen = 0;
      while (!seen && k < 8) begin
         @(negedge clk);
         k++;
         if (if0.stall) stalls++;
         if (if0.resp_valid) seen = 1;
      end
      chk({name, "_lat"}, 32'(k), 32'd3);
      chk({name, "_stall"}, 32'(stalls), 32'd3);
      chk({name, "_rdata"}, if0.read_data, erd);
      chk({name, "_err"}, 32'(if0.addr_err), 32'(eerr));
   endtask

   initial begin
      logic [5:0] e_resp;
      logic [5:0] e_ready;
      logic [5:0] e_stall;

      tab[0]  = '{"st10",   1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      tab[1]  = '{"ld10",   1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tab[2]  = '{"ld13",   1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
      tab[3]  = '{"ld10b",  1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tab[4]  = '{"st0",    1'b0, 1'b1, 32'h0,   32'h55667788, 32'h0,        1'b0};
      tab[5]  = '{"st_oor", 1'b0, 1'b1, 32'h100, 32'h1234,     32'h0,        1'b1};
      tab[6]  = '{"ld0",    1'b1, 1'b0, 32'h0,   32'h0,        32'h55667788, 1'b0};
      tab[7]  = '{"both",   1'b1, 1'b1, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
      tab[8]  = '{"none",   1'b0, 1'b0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
      tab[9]  = '{"ld10c",  1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tab[10] = '{"st20",   1'b0, 1'b1, 32'h20,  32'h11112222, 32'h0,        1'b0};

      if0.req_valid = 1'b0; if0.mem_read = 1'b0; if0.mem_write = 1'b0;
      if0.addr = 32'h0; if0.write_data = 32'h0;
      if1.req_valid = 1'b0; if1.mem_read = 1'b0; if1.mem_write = 1'b0;
      if1.addr = 32'h0; if1.write_data = 32'h0;

      // Reset values, and stall following req_valid while held in reset
      #12;
      chk("rst_ready", 32'(if0.req_ready), 32'd1);
      chk("rst_resp",  32'(if0.resp_valid), 32'd0);
      chk("rst_rdata", if0.read_data, 32'h0);
      chk("rst_err",   32'(if0.addr_err), 32'd0);
      chk("rst_stall0", 32'(if0.stall), 32'd0);
      if0.req_valid = 1'b1;
      #1;
      chk("rst_stall1", 32'(if0.stall), 32'd1);
      if0.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_req(tab[i].name, tab[i].rd, tab[i].wr, tab[i].a, tab[i].wd, tab[i].erd, tab[i].eerr);

      // Reset in the first WAIT cycle of a store drops the store
      @(negedge clk);
      if0.req_valid  = 1'b1;
      if0.mem_read   = 1'b0;
      if0.mem_write  = 1'b1;
      if0.addr       = 32'h20;
      if0.write_data = 32'hAAAA5555;
      @(posedge clk);
      #1;
      if0.req_valid = 1'b0;
      if0.mem_write = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(if0.req_ready), 32'd1);
      chk("mid_rst_resp",  32'(if0.resp_valid), 32'd0);
      chk("mid_rst_stall", 32'(if0.stall), 32'd0);
      chk("mid_rst_err",   32'(if0.addr_err), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      run_req("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0);

      // Response registers hold after the pulse
      @(negedge clk);
      chk("hold_resp",  32'(if0.resp_valid), 32'd0);
      chk("hold_rdata", if0.read_data, 32'h11112222);
      chk("hold_err",   32'(if0.addr_err), 32'd0);

      // LATENCY=1 back-to-back loads with req_valid held high.
      // Bit k is cycle T+k.
      e_resp  = 6'b100100;
      e_ready = 6'b001001;
      e_stall = 6'b011011;
      @(negedge clk);
      if1.req_valid = 1'b1;
      if1.mem_read  = 1'b1;
      if1.mem_write = 1'b0;
      if1.addr      = 32'h8;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk($sformatf("b2b_resp_%0d", k),  32'(if1.resp_valid), 32'(e_resp[k]));
         chk($sformatf("b2b_ready_%0d", k), 32'(if1.req_ready),  32'(e_ready[k]));
         chk($sformatf("b2b_stall_%0d", k), 32'(if1.stall),      32'(e_stall[k]));
      end
      if1.req_valid = 1'b0;
      if1.mem_read  = 1'b0;
      @(negedge clk);
      chk("b2b_idle_ready", 32'(if1.req_ready), 32'd1);
      chk("b2b_idle_err",   32'(if1.addr_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder that serves load/store requests from the pipeline's MEM stage over a valid/ready handshake. It replaces the zero-wait data memory with a parameterizable wait-state memory. It drives a stall to the pipeline while a request is outstanding. It returns read data, or an error flag for illegal or misaligned accesses, with a one-cycle response pulse.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; legal word index is 0..DEPTH-1.
- LATENCY, 2: wait cycles between accept and response; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request.
- mem_read  in  1  request is a load.
- mem_write  in  1  request is a store.
- addr  in  32  byte address; word index = addr[31:2].
- write_data  in  32  store data.
- req_ready  out  1  responder can accept; high only in IDLE.
- stall  out  1  combinational; pipeline must hold MEM and earlier stages while high.
- resp_valid  out  1  one-cycle response pulse.
- read_data  out  32  registered load result; valid when resp_valid=1.
- addr_err  out  1  registered; qualifies resp_valid; request was illegal.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - req_valid=1 → accept: latch addr, write_data, mem_read, mem_write; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - counter≠0 → decrement.
  - counter=0 → perform access; go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; always return to IDLE next edge.
  - No new request is accepted in RESP.
- Error conditions, evaluated on the latched request:
  - addr[1:0]≠0, or word index ≥DEPTH, or mem_read=mem_write (both high or both low).
- Error response: no array write, read_data=0, addr_err=1 in RESP.
- Legal load: read_data ← mem[index] at the WAIT→RESP edge; addr_err=0.
- Legal store: mem[index] ← write_data at the WAIT→RESP edge; read_data=0; addr_err=0.
- read_data and addr_err hold their values until the next WAIT→RESP edge.
- stall = (IDLE & req_valid) | WAIT. stall is low in RESP, so the pipeline latches read_data on the RESP→IDLE edge.
- Memory array is not reset; contents are undefined until written.

## Timing
- Request presented in cycle T (IDLE) → WAIT occupies cycles T+1..T+LATENCY → RESP in cycle T+LATENCY+1.
- Back-to-back throughput: one request per LATENCY+2 cycles. Next accept is possible earliest in cycle T+LATENCY+2.
- Inputs are sampled only at the accept edge; changes during WAIT/RESP are ignored.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, read_data=0, addr_err=0, counter=0. stall follows req_valid combinationally.
- Reset asserted mid-WAIT: request dropped, no write committed, FSM to IDLE immediately (asynchronous).
- Reset asserted in RESP: resp_valid drops immediately.
- Load of the word stored by the immediately preceding request returns the new value. The store commits before the next accept.

## Test plan
- Reset, then store 0xDEADBEEF to addr 0x10, then load 0x10. Required: each op has stall high for LATENCY+1 cycles, resp_valid pulses in cycle T+3 (LATENCY=2), and the load returns read_data=0xDEADBEEF with addr_err=0.
- Load from addr 0x13 (misaligned). Required: resp_valid with addr_err=1, read_data=0; a subsequent load of 0x10 still returns 0xDEADBEEF.
- Store 0x1234 to addr 4×DEPTH (out of range), then load addr 0. Required: addr_err=1 on the store response; the load returns the prior word 0 contents, unchanged.
- req_valid with mem_read=mem_write=1, then again with both low. Required: both give addr_err=1 with no array modification.
- Store 0xAAAA5555 to 0x20; assert rst_n=0 during cycle T+1 (WAIT); release; load 0x20. Required: resp_valid/req_ready at reset values immediately, and the load does not return 0xAAAA5555 (store dropped).
- Run with LATENCY=1 and two back-to-back loads with req_valid held high. Required: resp_valid in cycles T+2 and T+5, req_ready low in WAIT/RESP, and stall low only in RESP cycles.
